// File: rtl/and_gate_pkg.sv
// Shared constants, combo-index enum and saturation helper for the and_gate block.
package and_gate_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        COMBO_00 = 2'b00,
        COMBO_01 = 2'b01,
        COMBO_10 = 2'b10,
        COMBO_11 = 2'b11
    } combo_e;

    function automatic logic [31:0] sat_max(input int cnt_w);
        if (cnt_w >= 32)
            return 32'hFFFF_FFFF;
        else
            return (32'd1 << cnt_w) - 32'd1;
    endfunction

    function automatic combo_e combo_of(input logic a0, input logic b0);
        return combo_e'({a0, b0});
    endfunction

endpackage

// File: rtl/and_sat_counter.sv
// CNT_W-bit saturating up-counter with synchronous active-high clear.
module and_sat_counter
    import and_gate_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stick at MAX instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with combinational and 1-cycle registered results plus reduction flag.
// Lane-0 truth-table counters are built only when AND_STATS_EN is defined.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic             all_ones_q,
    output logic [CNT_W-1:0] cnt_00,
    output logic [CNT_W-1:0] cnt_01,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_11
);

    logic [WIDTH-1:0] and_w;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ao_q, ao_d;
    logic             vld_q, vld_d;

    assign and_w = a & b;
    assign out   = and_w;

    // Inputs are only sampled under in_valid, so idle-cycle garbage never enters state.
    always_comb begin
        data_d = data_q;
        ao_d   = ao_q;
        vld_d  = in_valid;
        if (in_valid) begin
            data_d = and_w;
            ao_d   = &and_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ao_q   <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ao_q   <= ao_d;
            vld_q  <= vld_d;
        end
    end

    assign out_q      = data_q;
    assign all_ones_q = ao_q;
    assign out_valid  = vld_q;

`ifdef AND_STATS_EN
    logic [CNT_W-1:0] cnt_w [4];
    combo_e           combo;

    assign combo = combo_of(a[0], b[0]);

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        and_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .clr_i (rst),
            .inc_i (in_valid && (combo == combo_e'(i))),
            .cnt_o (cnt_w[i])
        );
    end

    assign cnt_00 = cnt_w[COMBO_00];
    assign cnt_01 = cnt_w[COMBO_01];
    assign cnt_10 = cnt_w[COMBO_10];
    assign cnt_11 = cnt_w[COMBO_11];
`else
    assign cnt_00 = '0;
    assign cnt_01 = '0;
    assign cnt_10 = '0;
    assign cnt_11 = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate (WIDTH=8, CNT_W=2) with a queue-based scoreboard.
module tb_and_gate;

    localparam int W = 8;
    localparam int CW = 2;

    typedef struct packed {
        logic [W-1:0] q;
        logic         ao;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic          in_valid;
    logic [W-1:0]  out, out_q;
    logic          out_valid, all_ones_q;
    logic [CW-1:0] cnt_00, cnt_01, cnt_10, cnt_11;

    exp_t         sb[$];
    logic [W-1:0] hq;
    logic         hao;
    int           total = 0;
    int           bad = 0;

    and_gate #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .out        (out),
        .out_q      (out_q),
        .out_valid  (out_valid),
        .all_ones_q (all_ones_q),
        .cnt_00     (cnt_00),
        .cnt_01     (cnt_01),
        .cnt_10     (cnt_10),
        .cnt_11     (cnt_11)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic v);
        exp_t e;
        rst = r;
        a = aa;
        b = bb;
        in_valid = v;
        if (r) begin
            sb.delete();
        end else if (v) begin
            e.q  = aa & bb;
            e.ao = &(aa & bb);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, '0, '0, 1'b0);
        tick();
        tick();
        hq = '0;
        hao = 1'b0;
        total++;
        if (out_q !== '0 || out_valid !== 1'b0 || all_ones_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs out_q=%h vld=%b ao=%b want 00 0 0", out_q, out_valid, all_ones_q);
        end
        total++;
        if ({cnt_00, cnt_01, cnt_10, cnt_11} !== '0) begin
            bad++;
            $display("FAIL reset_cnt got %0d %0d %0d %0d want 0 0 0 0", cnt_00, cnt_01, cnt_10, cnt_11);
        end
    endtask

    task automatic test_truth_table();
        exp_t e;
        logic [W-1:0] aa, bb;
        for (int i = 0; i < 4; i++) begin
            aa = {7'b0, i[1]};
            bb = {7'b0, i[0]};
            drive(1'b0, aa, bb, 1'b1);
            #1;
            total++;
            if (out !== {7'b0, (i == 3)}) begin
                bad++;
                $display("FAIL truth_comb i=%0d out=%h want %h", i, out, {7'b0, (i == 3)});
            end
            tick();
            e = sb.pop_front();
            hq = e.q;
            hao = e.ao;
            total++;
            if (out_valid !== 1'b1 || out_q !== e.q || out_q !== {7'b0, (i == 3)}) begin
                bad++;
                $display("FAIL truth_reg i=%0d out_q=%h vld=%b want %h 1", i, out_q, out_valid, e.q);
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        hq = '0;
        hao = 1'b0;
        total++;
        if (out_q !== '0 || out_valid !== 1'b0 || all_ones_q !== 1'b0 ||
            {cnt_00, cnt_01, cnt_10, cnt_11} !== '0) begin
            bad++;
            $display("FAIL rst_prio out_q=%h vld=%b ao=%b cnt11=%0d want 00 0 0 0",
                     out_q, out_valid, all_ones_q, cnt_11);
        end
        drive(1'b0, 8'h01, 8'h01, 1'b1);
        tick();
        e = sb.pop_front();
        hq = e.q;
        hao = e.ao;
        total++;
        if (out_valid !== 1'b1 || out_q !== 8'h01) begin
            bad++;
            $display("FAIL rst_release out_q=%h vld=%b want 01 1", out_q, out_valid);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(1'b0, 8'hF0, 8'h3C, 1'b1);
        tick();
        e = sb.pop_front();
        hq = e.q;
        hao = e.ao;
        total++;
        if (out_valid !== 1'b1 || out_q !== 8'h30 || all_ones_q !== 1'b0 || e.q !== 8'h30) begin
            bad++;
            $display("FAIL hold_load out_q=%h ao=%b vld=%b want 30 0 1", out_q, all_ones_q, out_valid);
        end
        drive(1'b0, 8'hFF, 8'hFF, 1'b0);
        #1;
        total++;
        if (out !== 8'hFF) begin
            bad++;
            $display("FAIL hold_comb out=%h want ff", out);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_q !== hq || out_q !== 8'h30 || all_ones_q !== 1'b0) begin
            bad++;
            $display("FAIL hold_keep out_q=%h ao=%b vld=%b want 30 0 0", out_q, all_ones_q, out_valid);
        end
    endtask

    task automatic test_reduction();
        exp_t e;
        drive(1'b0, 8'hFF, 8'hFF, 1'b1);
        tick();
        e = sb.pop_front();
        hq = e.q;
        hao = e.ao;
        total++;
        if (out_valid !== 1'b1 || all_ones_q !== 1'b1 || out_q !== 8'hFF) begin
            bad++;
            $display("FAIL red_ones ao=%b out_q=%h want 1 ff", all_ones_q, out_q);
        end
        drive(1'b0, 8'hFF, 8'hFE, 1'b1);
        tick();
        e = sb.pop_front();
        hq = e.q;
        hao = e.ao;
        total++;
        if (out_valid !== 1'b1 || all_ones_q !== 1'b0 || out_q !== 8'hFE) begin
            bad++;
            $display("FAIL red_notones ao=%b out_q=%h want 0 fe", all_ones_q, out_q);
        end
        drive(1'b0, 'x, 'x, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0 || out_q !== 8'hFE || all_ones_q !== 1'b0) begin
            bad++;
            $display("FAIL idle_x out_q=%h ao=%b vld=%b want fe 0 0", out_q, all_ones_q, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [W-1:0] aa, bb;
        logic v;
        for (int i = 0; i < 24; i++) begin
            aa = W'($urandom);
            bb = (i % 5 == 0) ? aa : W'($urandom);
            if (i % 7 == 3) begin
                aa = 8'hFF;
                bb = 8'hFF;
            end
            v = (i < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(1'b0, aa, bb, v);
            #1;
            total++;
            if (out !== (aa & bb)) begin
                bad++;
                $display("FAIL b2b_comb i=%0d out=%h want %h", i, out, aa & bb);
            end
            tick();
            if (v) begin
                e = sb.pop_front();
                hq = e.q;
                hao = e.ao;
            end
            total++;
            if (out_valid !== v || out_q !== hq || all_ones_q !== hao) begin
                bad++;
                $display("FAIL b2b_reg i=%0d out_q=%h ao=%b vld=%b want %h %b %b",
                         i, out_q, all_ones_q, out_valid, hq, hao, v);
            end
        end
    endtask

    task automatic test_counters();
        exp_t e;
        logic [CW-1:0] x00, x01, x10, x11;
        drive(1'b1, '0, '0, 1'b0);
        tick();
        hq = '0;
        hao = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                drive(1'b0, 8'h01, 8'h01, 1'b1);
            else
                drive(1'b0, 8'h00, 8'h00, 1'b1);
            tick();
            e = sb.pop_front();
            hq = e.q;
            hao = e.ao;
        end
        drive(1'b0, 8'h01, 8'h00, 1'b0);
        tick();
`ifdef AND_STATS_EN
        x00 = 2'd1; x01 = 2'd0; x10 = 2'd0; x11 = 2'd3;
`else
        x00 = 2'd0; x01 = 2'd0; x10 = 2'd0; x11 = 2'd0;
`endif
        total++;
        if (cnt_11 !== x11) begin
            bad++;
            $display("FAIL cnt_11 got %0d want %0d", cnt_11, x11);
        end
        total++;
        if (cnt_00 !== x00 || cnt_01 !== x01 || cnt_10 !== x10) begin
            bad++;
            $display("FAIL cnt_other got %0d %0d %0d want %0d %0d %0d",
                     cnt_00, cnt_01, cnt_10, x00, x01, x10);
        end
        total++;
        if (out_q !== 8'h00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL cnt_path out_q=%h vld=%b want 00 0", out_q, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        test_reset();
        test_truth_table();
        test_reset_priority();
        test_hold();
        test_reduction();
        test_back_to_back();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "bench timeout");
    end

endmodule
